// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: the address tracks pc, the ack is followed one cycle later by instr_valid, and instr is held until instr_ready.
// Redirects retarget the PC. Optional REQ watchdog (macro FETCH_TIMEOUT_EN) raises a sticky fault.
module pc_fetch_ctrl #(
  parameter int              PC_W     = 20,
  parameter int              INSTR_W  = 20,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    pc,
  output logic               fault
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    pend_pc_q, pend_pc_d;
  logic               pend_q, pend_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               vld_q, vld_d;
  logic               req_q, req_d;
  logic               fault_q, fault_d;
  logic               timeout_hit;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts REQ cycles without ack; any ack or exit from REQ restarts it.
  always_comb begin
    timeout_hit = (state_q == S_REQ) && !mem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));
    cnt_d       = '0;
    if ((state_q == S_REQ) && !mem_ack && !timeout_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    pend_d    = pend_q;
    instr_d   = instr_q;
    vld_d     = vld_q;
    fault_d   = fault_q;

    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (run && !fault_q) begin
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        // A redirect here cannot cancel the bus cycle; remember the newest target.
        if (redirect) begin
          pend_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end
        if (timeout_hit) begin
          fault_d = 1'b1;
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end else if (mem_ack) begin
          if (redirect || pend_q) begin
            pc_d    = redirect ? redirect_pc : pend_pc_q;
            pend_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = mem_data;
            vld_d   = 1'b1;
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          vld_d   = 1'b0;
          state_d = run ? S_REQ : S_IDLE;
        end else if (instr_ready) begin
          pc_d    = pc_q + PC_W'(1);
          vld_d   = 1'b0;
          state_d = run ? S_REQ : S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        vld_d   = 1'b0;
      end
    endcase

    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      pend_q    <= 1'b0;
      instr_q   <= '0;
      vld_q     <= 1'b0;
      req_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      pend_q    <= pend_d;
      instr_q   <= instr_d;
      vld_q     <= vld_d;
      req_q     <= req_d;
      fault_q   <= fault_d;
    end
  end

  assign mem_req     = req_q;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = vld_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed and randomized checks of pc_fetch_ctrl against a transaction-level PC/instruction model.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, run, mem_req, mem_ack, instr_valid, instr_ready, redirect, fault;
  logic [19:0] mem_addr, mem_data, instr, redirect_pc, pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.PC_W(20), .INSTR_W(20), .RESET_PC(20'h00000), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .pc(pc), .fault(fault)
  );

  function automatic logic [19:0] hash(input logic [19:0] a);
    return {a[9:0], a[19:10]} ^ 20'h5A5A5;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expects a request at addr; answers after dly idle cycles and checks the delivered word.
  task automatic fetch_one(input logic [19:0] addr, input int dly, input logic [19:0] data);
    chk("req_vld", 32'(mem_req), 32'd1);
    chk("req_addr", 32'(mem_addr), 32'(addr));
    for (int k = 0; k < dly; k++) begin
      tick();
      chk("req_stable", 32'(mem_req), 32'd1);
      chk("req_addr_stable", 32'(mem_addr), 32'(addr));
      chk("no_early_vld", 32'(instr_valid), 32'd0);
    end
    mem_ack  = 1'b1;
    mem_data = data;
    tick();
    mem_ack  = 1'b0;
    chk("ack_vld", 32'(instr_valid), 32'd1);
    chk("ack_instr", 32'(instr), 32'(data));
    chk("ack_req_drop", 32'(mem_req), 32'd0);
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  logic [19:0] exp_pc;
  logic        exp_vld, nxt_vld;
  int          req_wait, accepts;

  initial begin
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_data = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) tick();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_vld", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_fault", 32'(fault), 32'd0);

    // First fetch, two wait cycles, then held while the consumer stalls.
    rst = 1'b0; run = 1'b1;
    tick();
    fetch_one(20'h00000, 2, 20'hABCDE);
    repeat (2) tick();
    chk("hold_vld", 32'(instr_valid), 32'd1);
    chk("hold_instr", 32'(instr), 32'hABCDE);
    chk("hold_pc", 32'(pc), 32'h0);

    for (int i = 1; i <= 3; i++) begin
      accept();
      fetch_one(20'(i), 0, hash(20'(i)));
    end

    // PC wrap from all-ones.
    redirect = 1'b1; redirect_pc = 20'hFFFFF;
    tick();
    redirect = 1'b0;
    chk("redir_hold_vld", 32'(instr_valid), 32'd0);
    fetch_one(20'hFFFFF, 1, hash(20'hFFFFF));
    accept();
    chk("wrap_addr", 32'(mem_addr), 32'h0);
    chk("wrap_req", 32'(mem_req), 32'd1);

    // Redirect beats instr_ready in HOLD.
    fetch_one(20'h00000, 0, hash(20'h0));
    redirect = 1'b1; redirect_pc = 20'h00400; instr_ready = 1'b1;
    tick();
    redirect = 1'b0; instr_ready = 1'b0;
    chk("redir_drop_vld", 32'(instr_valid), 32'd0);
    chk("redir_addr", 32'(mem_addr), 32'h00400);
    chk("redir_req", 32'(mem_req), 32'd1);

    // Redirect during REQ: ack three cycles later is discarded.
    redirect = 1'b1; redirect_pc = 20'h00100;
    tick();
    redirect = 1'b0;
    chk("pend_addr_stable", 32'(mem_addr), 32'h00400);
    repeat (2) tick();
    mem_ack = 1'b1; mem_data = 20'h11111;
    tick();
    mem_ack = 1'b0;
    chk("pend_no_vld", 32'(instr_valid), 32'd0);
    chk("pend_new_addr", 32'(mem_addr), 32'h00100);
    chk("pend_new_req", 32'(mem_req), 32'd1);
    fetch_one(20'h00100, 1, hash(20'h00100));
    accept();

    // Two redirects in REQ, the second coinciding with the ack: last one wins.
    redirect = 1'b1; redirect_pc = 20'h00200;
    tick();
    redirect_pc = 20'h00300; mem_ack = 1'b1; mem_data = 20'h22222;
    tick();
    redirect = 1'b0; mem_ack = 1'b0;
    chk("last_redir_vld", 32'(instr_valid), 32'd0);
    chk("last_redir_addr", 32'(mem_addr), 32'h00300);
    fetch_one(20'h00300, 0, hash(20'h00300));

    // run low: finish the held word then idle; stray acks and IDLE redirects.
    run = 1'b0;
    accept();
    chk("idle_req", 32'(mem_req), 32'd0);
    chk("idle_pc", 32'(pc), 32'h00301);
    mem_ack = 1'b1; mem_data = 20'h33333;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_ignored", 32'(instr_valid), 32'd0);
    redirect = 1'b1; redirect_pc = 20'h00555;
    tick();
    redirect = 1'b0;
    chk("idle_redir_pc", 32'(pc), 32'h00555);
    chk("idle_redir_req", 32'(mem_req), 32'd0);
    run = 1'b1;
    tick();
    run = 1'b0;
    fetch_one(20'h00555, 2, hash(20'h00555));
    accept();
    chk("run_low_idle", 32'(mem_req), 32'd0);
    chk("run_low_pc", 32'(pc), 32'h00556);

    // Asynchronous reset while requesting.
    run = 1'b1;
    tick();
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(mem_req), 32'd0);
    chk("async_rst_pc", 32'(pc), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_addr", 32'(mem_addr), 32'h0);
    chk("post_rst_req", 32'(mem_req), 32'd1);

`ifdef FETCH_TIMEOUT_EN
    repeat (14) tick();
    chk("to_before_req", 32'(mem_req), 32'd1);
    chk("to_before_fault", 32'(fault), 32'd0);
    tick();
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_req_drop", 32'(mem_req), 32'd0);
    repeat (3) tick();
    chk("to_stuck_idle", 32'(mem_req), 32'd0);
    chk("to_sticky", 32'(fault), 32'd1);
    rst = 1'b1;
    tick();
    chk("to_rst_clear", 32'(fault), 32'd0);
    rst = 1'b0;
    tick();
    chk("to_restart_addr", 32'(mem_addr), 32'h0);
    chk("to_restart_req", 32'(mem_req), 32'd1);
`else
    repeat (30) tick();
    chk("no_to_req", 32'(mem_req), 32'd1);
    chk("no_to_fault", 32'(fault), 32'd0);
`endif

    // Randomized traffic against the model: exp_pc is the address of the next word owed.
    rst = 1'b1;
    tick();
    rst = 1'b0; run = 1'b1;
    tick();
    exp_pc = 20'h0; exp_vld = 1'b0; req_wait = 0; accepts = 0;
    for (int it = 0; it < 600; it++) begin
      chk("rnd_vld", 32'(instr_valid), 32'(exp_vld));
      chk("rnd_req", 32'(mem_req), 32'(!exp_vld));
      if (exp_vld) chk("rnd_instr", 32'(instr), 32'(hash(exp_pc)));
      else         chk("rnd_addr", 32'(mem_addr), 32'(exp_pc));
      mem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
      nxt_vld = exp_vld;
      if (!exp_vld) begin
        if ($urandom_range(2, 0) == 0 || req_wait >= 8) begin
          mem_ack  = 1'b1;
          mem_data = hash(mem_addr);
          nxt_vld  = 1'b1;
          req_wait = 0;
        end else begin
          req_wait++;
        end
      end else begin
        case ($urandom_range(7, 0))
          0: begin
            redirect    = 1'b1;
            redirect_pc = 20'($urandom());
            instr_ready = 1'($urandom_range(1, 0));
            exp_pc      = redirect_pc;
            nxt_vld     = 1'b0;
          end
          1, 2, 3: begin
            instr_ready = 1'b1;
            exp_pc      = exp_pc + 20'd1;
            nxt_vld     = 1'b0;
            accepts++;
          end
          default: begin
            mem_ack  = 1'($urandom_range(1, 0));
            mem_data = 20'($urandom());
          end
        endcase
      end
      tick();
      exp_vld = nxt_vld;
    end
    mem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    chk("rnd_progress", 32'(accepts > 20), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
